// File: rtl/sampler_a_ext.sv
// sampler_a_ext: ExpandA rejection sampler for one polynomial of matrix A.
// Absorbs rho||L||K into an external SHAKE128 core, buffers the squeezed
// stream, and rejection-samples 23-bit candidates into coefficients mod q.
// The coefficients are emitted SAMPLER_W at a time with a valid/ready handshake.
module sampler_a_ext #(
    parameter int SAMPLER_W = 4,
    parameter int SAMPLE_W  = 23,
    parameter int W         = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          re_sample,
    input  logic [3:0]                    K,
    input  logic [3:0]                    L,
    input  logic                          valid_seed,
    output logic                          ready,
    input  logic [W-1:0]                  seed_i,
    output logic [SAMPLER_W*SAMPLE_W-1:0] samples,
    output logic                          valid_o,
    input  logic                          ready_o,
    output logic                          done,
    output logic                          rst_k,
    output logic [63:0]                   din,
    input  logic [63:0]                   dout,
    output logic                          src_ready,
    input  logic                          src_read,
    input  logic                          dst_write,
    output logic                          dst_ready
);

    localparam int SEED_WORDS = 4;
    localparam int BEATS      = 256 / SAMPLER_W;
    localparam int BEAT_W     = $clog2(BEATS);
    localparam int SLOT_W     = $clog2(SAMPLER_W);
    localparam logic [SAMPLE_W-1:0] Q      = SAMPLE_W'(8380417);
    // SHAKE128 domain nibble, message length 272 bits (rho 256 + nonce 16)
    localparam logic [63:0]         HEADER = {4'h1, 44'b0, 16'd272};

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_KRST, S_ABSORB, S_SQUEEZE, S_FLUSH
    } state_t;

    state_t              state_reg, state_next;
    logic [1:0]          seed_cnt_reg;
    logic [2:0]          abs_cnt_reg;
    logic [3:0]          k_reg, l_reg;
    logic [127:0]        bit_buf_reg, bit_buf_next, bit_buf_shift;
    logic [7:0]          buf_cnt_reg, buf_cnt_next, buf_cnt_shift;
    logic [SLOT_W-1:0]   slot_cnt_reg;
    logic [BEAT_W-1:0]   beat_cnt_reg;
    logic                valid_reg, done_reg, rst_k_reg, rst_k_next;
    logic [W-1:0]        rho_words [SEED_WORDS];
    logic [SAMPLE_W-1:0] cand;
    logic                seed_fire, abs_fire, fill_fire, cand_fire, cand_ok;
    logic                beat_fire, last_beat;

    assign valid_o = valid_reg;
    assign done    = done_reg;
    assign rst_k   = rst_k_reg;

    // Candidate is the low three buffered bytes with the top bit of byte 2 dropped
    assign cand      = bit_buf_reg[SAMPLE_W-1:0];
    assign cand_ok   = (cand < Q);
    assign seed_fire = ready && valid_seed;
    assign abs_fire  = src_ready && src_read;
    assign fill_fire = dst_ready && dst_write;
    assign cand_fire = (state_reg == S_SQUEEZE) && !valid_reg && (buf_cnt_reg >= 8'd24);
    assign beat_fire = valid_reg && ready_o;
    assign last_beat = beat_fire && (beat_cnt_reg == BEAT_W'(BEATS - 1));

    // Seed word storage: one register per rho word, persists across re_sample
    for (genvar gi = 0; gi < SEED_WORDS; gi++) begin : g_rho
        logic [W-1:0] word_reg;
        // Capture word gi when the load counter points at it
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                word_reg <= '0;
            end else if (seed_fire && seed_cnt_reg == 2'(gi)) begin
                word_reg <= seed_i;
            end
        end
        assign rho_words[gi] = word_reg;
    end

    // Output coefficient slots, filled in order by accepted candidates
    for (genvar gi = 0; gi < SAMPLER_W; gi++) begin : g_slot
        logic [SAMPLE_W-1:0] slot_reg;
        // Slot gi only changes while the beat is not being offered
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                slot_reg <= '0;
            end else if (cand_fire && cand_ok && slot_cnt_reg == SLOT_W'(gi)) begin
                slot_reg <= cand;
            end
        end
        assign samples[gi*SAMPLE_W +: SAMPLE_W] = slot_reg;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= S_IDLE;
        else      state_reg <= state_next;
    end

    // Next-state logic; start/re_sample only matter in IDLE
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start)          state_next = S_LOAD;
                else if (re_sample) state_next = S_KRST;
            end
            S_LOAD:    if (seed_fire && seed_cnt_reg == 2'd3) state_next = S_KRST;
            S_KRST:    state_next = S_ABSORB;
            S_ABSORB:  if (abs_fire && abs_cnt_reg == 3'd5) state_next = S_SQUEEZE;
            S_SQUEEZE: if (last_beat) state_next = S_FLUSH;
            S_FLUSH:   state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Output logic: handshake enables, absorb word mux, Keccak reset request
    always_comb begin
        ready      = 1'b0;
        src_ready  = 1'b0;
        dst_ready  = 1'b0;
        din        = '0;
        case (state_reg)
            S_LOAD:    ready = 1'b1;
            S_ABSORB: begin
                src_ready = 1'b1;
                case (abs_cnt_reg)
                    3'd0:    din = HEADER;
                    3'd1:    din = rho_words[0];
                    3'd2:    din = rho_words[1];
                    3'd3:    din = rho_words[2];
                    3'd4:    din = rho_words[3];
                    3'd5:    din = {48'b0, 4'b0, k_reg, 4'b0, l_reg};
                    default: din = '0;
                endcase
            end
            S_SQUEEZE: dst_ready = (buf_cnt_reg <= 8'd64);
            default:   ;
        endcase
        rst_k_next = (state_next == S_KRST) || (state_next == S_FLUSH);
    end

    // Bit buffer: drop a consumed candidate, then append a squeezed word above the rest
    always_comb begin
        bit_buf_shift = cand_fire ? (bit_buf_reg >> 24) : bit_buf_reg;
        buf_cnt_shift = cand_fire ? (buf_cnt_reg - 8'd24) : buf_cnt_reg;
        bit_buf_next  = bit_buf_shift;
        buf_cnt_next  = buf_cnt_shift;
        if (fill_fire) begin
            bit_buf_next = bit_buf_shift | ({64'b0, dout} << buf_cnt_shift);
            buf_cnt_next = buf_cnt_shift + 8'd64;
        end
    end

    // Datapath control: counters, nonce latch, beat handshake, pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seed_cnt_reg <= '0;
            abs_cnt_reg  <= '0;
            k_reg        <= '0;
            l_reg        <= '0;
            bit_buf_reg  <= '0;
            buf_cnt_reg  <= '0;
            slot_cnt_reg <= '0;
            beat_cnt_reg <= '0;
            valid_reg    <= 1'b0;
            done_reg     <= 1'b0;
            rst_k_reg    <= 1'b1;
        end else begin
            rst_k_reg <= rst_k_next;
            done_reg  <= last_beat;
            if (state_reg == S_IDLE && start) seed_cnt_reg <= '0;
            else if (seed_fire)               seed_cnt_reg <= seed_cnt_reg + 2'd1;
            if (state_reg == S_KRST) begin
                k_reg        <= K;
                l_reg        <= L;
                abs_cnt_reg  <= '0;
                bit_buf_reg  <= '0;
                buf_cnt_reg  <= '0;
                slot_cnt_reg <= '0;
                beat_cnt_reg <= '0;
                valid_reg    <= 1'b0;
            end else begin
                if (abs_fire) abs_cnt_reg <= abs_cnt_reg + 3'd1;
                bit_buf_reg <= bit_buf_next;
                buf_cnt_reg <= buf_cnt_next;
                if (cand_fire && cand_ok) begin
                    if (slot_cnt_reg == SLOT_W'(SAMPLER_W - 1)) begin
                        slot_cnt_reg <= '0;
                        valid_reg    <= 1'b1;
                    end else begin
                        slot_cnt_reg <= slot_cnt_reg + 1'b1;
                    end
                end
                if (beat_fire) begin
                    valid_reg    <= 1'b0;
                    beat_cnt_reg <= beat_cnt_reg + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sampler_a_ext.sv
// tb_sampler_a_ext: randomized bench for sampler_a_ext. A Keccak stub feeds
// a generated byte stream; the reference model rejection-samples the same
// bytes directly and the beats are compared in order.
module tb_sampler_a_ext;

    localparam int Q = 8380417;

    logic        clk, rst, start, re_sample, valid_seed, ready;
    logic [3:0]  K, L;
    logic [63:0] seed_i, din, dout;
    logic [91:0] samples;
    logic        valid_o, ready_o, done, rst_k;
    logic        src_ready, src_read, dst_write, dst_ready;

    sampler_a_ext dut (
        .clk(clk), .rst(rst), .start(start), .re_sample(re_sample),
        .K(K), .L(L), .valid_seed(valid_seed), .ready(ready), .seed_i(seed_i),
        .samples(samples), .valid_o(valid_o), .ready_o(ready_o), .done(done),
        .rst_k(rst_k), .din(din), .dout(dout), .src_ready(src_ready),
        .src_read(src_read), .dst_write(dst_write), .dst_ready(dst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference state
    logic [63:0] rho_m [4];
    logic [63:0] exp_abs [6];
    logic [22:0] exp_coef [256];
    logic [63:0] stub_q [$];
    int          beat, abs_idx, done_cnt, rk_cnt, hold_beat, hold_left;
    bit          held;
    logic [91:0] snap;

    // Build a stream of 3-byte candidates with many boundary values, then
    // derive the expected coefficients straight from the byte list.
    task automatic make_stream(input bit directed);
        logic [7:0]  bq [$];
        logic [7:0]  d [12];
        logic [22:0] c;
        logic [63:0] w;
        int acc, n;
        stub_q.delete();
        if (directed) begin
            d = '{8'hFF, 8'hFF, 8'h7F, 8'h01, 8'hE0, 8'h7F,
                  8'h00, 8'hE0, 8'h7F, 8'h05, 8'h00, 8'h80};
            foreach (d[i]) bq.push_back(d[i]);
        end
        acc = 0;
        while (acc < 262) begin
            case ($urandom_range(0, 9))
                0:       c = 23'(Q + $urandom_range(0, 8190));
                1:       c = 23'(Q - 1);
                2:       c = 23'(Q);
                3:       c = 23'd0;
                default: c = 23'($urandom);
            endcase
            if (int'(c) < Q) acc++;
            bq.push_back(c[7:0]);
            bq.push_back(c[15:8]);
            bq.push_back({1'($urandom), c[22:16]});
        end
        while (bq.size() % 8 != 0) bq.push_back(8'($urandom));
        repeat (16) bq.push_back(8'($urandom));
        for (int j = 0; j < bq.size() / 8; j++) begin
            w = '0;
            for (int b = 0; b < 8; b++) w[8*b +: 8] = bq[8*j + b];
            stub_q.push_back(w);
        end
        n = 0;
        for (int i = 0; i + 2 < bq.size() && n < 256; i += 3) begin
            c = {bq[i+2][6:0], bq[i+1], bq[i]};
            if (int'(c) < Q) begin
                exp_coef[n] = c;
                n++;
            end
        end
    endtask

    // Environment: Keccak absorb/squeeze stub, consumer, pulse monitors
    initial begin
        logic [91:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                src_read = 1'b0; dst_write = 1'b0; ready_o = 1'b0;
            end else begin
                if (rst_k) rk_cnt++;
                if (done) begin
                    done_cnt++;
                    check("rst_k_with_done", 128'(rst_k), 128'(1));
                    check("dst_ready_at_done", 128'(dst_ready), 128'(0));
                end
                src_read = ($urandom_range(0, 2) != 0);
                if (src_read && src_ready) begin
                    if (abs_idx == 0) check("rst_k_pulse_before_header", 128'(rk_cnt), 128'(1));
                    if (abs_idx < 6) check($sformatf("din_%0d", abs_idx), 128'(din), 128'(exp_abs[abs_idx]));
                    else check("din_count", 128'(abs_idx), 128'(5));
                    abs_idx++;
                end
                dst_write = 1'b0;
                if (dst_ready && stub_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                    dst_write = 1'b1;
                    dout = stub_q.pop_front();
                end else if (!dst_ready && $urandom_range(0, 5) == 0) begin
                    dst_write = 1'b1;
                    dout = {$urandom, $urandom};
                end
                if (hold_left > 0) begin
                    ready_o = 1'b0;
                    check("hold_valid", 128'(valid_o), 128'(1));
                    check("hold_samples", 128'(samples), 128'(snap));
                    hold_left--;
                end else if (valid_o && beat == hold_beat && !held) begin
                    held = 1'b1; snap = samples; hold_left = 10; ready_o = 1'b0;
                end else begin
                    ready_o = ($urandom_range(0, 3) != 0);
                    if (ready_o && valid_o) begin
                        if (beat < 64) begin
                            for (int i = 0; i < 4; i++) e[i*23 +: 23] = exp_coef[beat*4 + i];
                            check($sformatf("beat_%0d", beat), 128'(samples), 128'(e));
                        end else begin
                            check("beat_count", 128'(beat), 128'(63));
                        end
                        beat++;
                    end
                end
            end
        end
    end

    task automatic run_poly(input bit do_load, input logic [3:0] k, input logic [3:0] l,
                            input bit directed, input int hold_b, input int abort_beats);
        int guard, w;
        exp_abs[0] = {4'h1, 44'b0, 16'd272};
        for (int i = 0; i < 4; i++) exp_abs[i+1] = rho_m[i];
        exp_abs[5] = {48'b0, 4'b0, k, 4'b0, l};
        make_stream(directed);
        beat = 0; abs_idx = 0; done_cnt = 0; rk_cnt = 0;
        hold_beat = hold_b; held = 1'b0; hold_left = 0;
        K = k; L = l;
        @(negedge clk);
        if (do_load) start = 1'b1; else re_sample = 1'b1;
        @(negedge clk);
        start = 1'b0; re_sample = 1'b0;
        if (do_load) begin
            w = 0; guard = 0;
            while (w < 4 && guard < 100) begin
                valid_seed = 1'($urandom_range(0, 1));
                seed_i = valid_seed ? rho_m[w] : {$urandom, $urandom};
                if (valid_seed && ready) w++;
                guard++;
                @(negedge clk);
            end
            valid_seed = 1'b0;
            check("seed_words_taken", 128'(w), 128'(4));
        end
        guard = 0;
        while (!src_ready && guard < 50) begin @(negedge clk); guard++; end
        check("absorb_reached", 128'(src_ready), 128'(1));
        // Mid-run noise: new K/L and stray start/re_sample must be ignored
        K = 4'($urandom); L = 4'($urandom);
        start = 1'b1; re_sample = 1'b1;
        @(negedge clk);
        start = 1'b0; re_sample = 1'b0;
        if (abort_beats > 0) begin
            guard = 0;
            while (beat < abort_beats && guard < 5000) begin @(negedge clk); guard++; end
            check("abort_point_reached", 128'(beat >= abort_beats), 128'(1));
            rst = 1'b0;
            #1;
            check("mid_rst_valid_o", 128'(valid_o), 128'(0));
            check("mid_rst_ready", 128'(ready), 128'(0));
            check("mid_rst_done", 128'(done), 128'(0));
            check("mid_rst_rst_k", 128'(rst_k), 128'(1));
            check("mid_rst_samples", 128'(samples), 128'(0));
            check("mid_rst_dst_ready", 128'(dst_ready), 128'(0));
            check("mid_rst_src_ready", 128'(src_ready), 128'(0));
            for (int i = 0; i < 4; i++) rho_m[i] = '0;
            stub_q.delete();
            repeat (3) @(negedge clk);
            rst = 1'b1;
            repeat (3) @(negedge clk);
        end else begin
            guard = 0;
            while (done_cnt == 0 && guard < 8000) begin @(negedge clk); guard++; end
            repeat (4) @(negedge clk);
            check("done_pulses", 128'(done_cnt), 128'(1));
            check("beats_total", 128'(beat), 128'(64));
            check("absorb_words", 128'(abs_idx), 128'(6));
            check("rst_k_cycles", 128'(rk_cnt), 128'(2));
            check("idle_valid_o", 128'(valid_o), 128'(0));
            check("idle_dst_ready", 128'(dst_ready), 128'(0));
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; re_sample = 1'b0; K = '0; L = '0;
        valid_seed = 1'b0; seed_i = '0;
        beat = 0; abs_idx = 0; done_cnt = 0; rk_cnt = 0;
        hold_beat = -1; hold_left = 0; held = 1'b0; snap = '0;
        for (int i = 0; i < 4; i++) rho_m[i] = '0;
        repeat (3) @(negedge clk);
        check("reset_ready", 128'(ready), 128'(0));
        check("reset_valid_o", 128'(valid_o), 128'(0));
        check("reset_done", 128'(done), 128'(0));
        check("reset_rst_k", 128'(rst_k), 128'(1));
        check("reset_samples", 128'(samples), 128'(0));
        check("reset_src_ready", 128'(src_ready), 128'(0));
        check("reset_dst_ready", 128'(dst_ready), 128'(0));
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Directed seed and candidates, long stall at beat 2
        rho_m[0] = 64'h0706050403020100; rho_m[1] = 64'h0F0E0D0C0B0A0908;
        rho_m[2] = 64'h1716151413121110; rho_m[3] = 64'h1F1E1D1C1B1A1918;
        run_poly(1'b1, 4'd1, 4'd2, 1'b1, 2, 0);
        // Next polynomial with the stored rho
        run_poly(1'b0, 4'd0, 4'd1, 1'b0, -1, 0);
        // All-zero seed and nonce
        for (int i = 0; i < 4; i++) rho_m[i] = '0;
        run_poly(1'b1, 4'd0, 4'd0, 1'b0, -1, 0);
        // Reset in the middle of squeezing
        for (int i = 0; i < 4; i++) rho_m[i] = {$urandom, $urandom};
        run_poly(1'b1, 4'd5, 4'd9, 1'b0, -1, 10);
        // re_sample straight after reset uses the cleared rho
        run_poly(1'b0, 4'd3, 4'd7, 1'b0, -1, 0);
        // Fresh seed, maximal nibbles, stall on the final beat
        for (int i = 0; i < 4; i++) rho_m[i] = {$urandom, $urandom};
        run_poly(1'b1, 4'd15, 4'd15, 1'b0, 63, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
